udp_cmd_parser: RTL and testbench
=================================

UDP_CMD_PARSER -- requirements
Module: udp_cmd_parser

Purpose: consumes the 8-bit UDP payload AXI-Stream from the UDP stack, decodes 3-byte LED commands, returns a 3-byte reply stream.

Interface
REQ-001 SHALL have parameter MAGIC, default 8'hA5, required value of command byte 0.
REQ-002 SHALL have parameter LED_RESET, default 8'h00, reset value of led.
REQ-003 clk  input  1  single clock, 125 MHz domain; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 s_udp_payload_axis_tdata  input  8  RX payload byte.
REQ-006 s_udp_payload_axis_tvalid  input  1  RX byte valid.
REQ-007 s_udp_payload_axis_tready  output  1  RX byte accepted when tvalid&tready.
REQ-008 s_udp_payload_axis_tlast  input  1  last byte of frame.
REQ-009 s_udp_payload_axis_tuser  input  1  frame error; meaningful only on tlast beat.
REQ-010 m_udp_payload_axis_tdata  output  8  reply byte.
REQ-011 m_udp_payload_axis_tvalid  output  1  reply byte valid.
REQ-012 m_udp_payload_axis_tready  input  1  downstream accept.
REQ-013 m_udp_payload_axis_tlast  output  1  last reply byte.
REQ-014 m_udp_payload_axis_tuser  output  1  tied 0.
REQ-015 led  output  8  LED register.
REQ-016 good_frame_cnt  output  16  accepted-command count.
REQ-017 bad_frame_cnt  output  16  discarded-frame count.

Function
REQ-018 Frame format SHALL be byte0=MAGIC, byte1=OP, byte2=ARG; bytes beyond 3 SHALL be accepted and ignored.
REQ-019 FSM states SHALL be B0, B1, B2, DRAIN, RESP; reset state B0.
REQ-020 s_tready SHALL be 1 in B0/B1/B2/DRAIN and 0 in RESP.
REQ-021 Transitions: B0 -> B1 on accepted byte w/o tlast; B1 -> B2 likewise, OP latched; B2 -> DRAIN on accepted byte w/o tlast, ARG latched; DRAIN holds until tlast beat.
REQ-022 A frame SHALL be good iff byte0==MAGIC, length>=3, and tuser==0 on its tlast beat; otherwise bad.
REQ-023 Bad magic SHALL send FSM to DRAIN (or B0 if that byte has tlast); tlast in B0 or B1 (length<3) SHALL be bad.
REQ-024 On tlast beat of a bad frame: led unchanged, no reply, bad_frame_cnt+1, next state B0.
REQ-025 On tlast beat of a good frame (in B2 or DRAIN), at that same clock edge: execute OP, good_frame_cnt+1, load reply, next state RESP.
REQ-026 OP 8'h01: led<=ARG; OP 8'h02: led unchanged (read); OP 8'h03: led<=led^ARG; any other OP: led unchanged, NACK.
REQ-027 Reply SHALL be 3 bytes: MAGIC; OP|8'h80 (known OP) or 8'hFF (unknown); led value after execution.
REQ-028 led and first reply beat SHALL both become visible 1 cycle after the tlast beat is accepted.
REQ-029 In RESP, m_tvalid=1; a byte SHALL advance only on m_tvalid&m_tready; tdata SHALL stay stable while stalled; tlast=1 on byte 3 only.
REQ-030 After byte 3 is accepted, m_tvalid SHALL be 0 next cycle and FSM SHALL return to B0; no bubble requirement beyond that.
REQ-031 Counters SHALL saturate at 16'hFFFF, never wrap.
REQ-032 tvalid low SHALL stall parsing with no state change; tdata/tuser ignored when tvalid=0.
REQ-033 m_tvalid SHALL be 0 in all states except RESP.

Reset
REQ-034 While rst=1 at a clock edge: FSM->B0, led<=LED_RESET, counters<=0, m_tvalid<=0, m_tlast<=0, reply cleared.
REQ-035 s_tready SHALL be 0 during reset and 1 the cycle after rst deasserts.
REQ-036 rst mid-frame or mid-reply SHALL abort it: partial frame not executed, no counter change, remaining reply bytes dropped.

Verification
REQ-037 Frame A5 01 3C (tlast on 3rd) -> led=8'h3C 1 cycle later; reply A5 81 3C with tlast on 3C; good_frame_cnt=1.
REQ-038 led=8'h3C, frame A5 03 FF 00 00 (5 bytes) -> led=8'hC3; reply A5 83 C3; extra bytes consumed.
REQ-039 Frame 5A 01 11, frame A5 01 (2 bytes), frame A5 01 22 with tuser=1 on tlast -> led unchanged, no reply beats, bad_frame_cnt=3.
REQ-040 Frame A5 07 55 with m_tready=0 for 10 cycles -> reply byte0 A5 held stable, s_tready=0 throughout; then A5 FF <led> with led unchanged.
REQ-041 rst pulse after 2nd reply byte -> m_tvalid=0 next cycle, led=LED_RESET, counters 0; next A5 02 00 -> reply A5 82 00.
REQ-042 Force good_frame_cnt to 16'hFFFF then send valid frame -> count stays 16'hFFFF.

Source files
------------

// File: rtl/udp_cmd_parser.sv
`timescale 1ns/1ps
// udp_cmd_parser: decodes 3-byte LED commands (MAGIC, OP, ARG) carried in a UDP
// payload stream and answers every good command with a 3-byte reply stream.
module udp_cmd_parser #(
    parameter logic [7:0] MAGIC     = 8'hA5,
    parameter logic [7:0] LED_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_udp_payload_axis_tdata,
    input  logic        s_udp_payload_axis_tvalid,
    output logic        s_udp_payload_axis_tready,
    input  logic        s_udp_payload_axis_tlast,
    input  logic        s_udp_payload_axis_tuser,
    output logic [7:0]  m_udp_payload_axis_tdata,
    output logic        m_udp_payload_axis_tvalid,
    input  logic        m_udp_payload_axis_tready,
    output logic        m_udp_payload_axis_tlast,
    output logic        m_udp_payload_axis_tuser,
    output logic [7:0]  led,
    output logic [15:0] good_frame_cnt,
    output logic [15:0] bad_frame_cnt
);

    typedef enum logic [2:0] {B0, B1, B2, DRAIN, RESP} state_t;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_XOR   = 8'h03;

    state_t      r_state;
    logic        r_s_tready;
    logic [7:0]  r_m_tdata;
    logic        r_m_tvalid;
    logic        r_m_tlast;
    logic [7:0]  r_led;
    logic [15:0] r_good_cnt;
    logic [15:0] r_bad_cnt;
    logic [7:0]  r_op;
    logic [7:0]  r_arg;
    logic        r_bad_magic;
    logic [7:0]  r_rsp_b1;
    logic [7:0]  r_rsp_b2;
    logic [1:0]  r_rsp_idx;

    logic        w_accept;
    logic        w_end_good;
    logic        w_end_bad;
    logic        w_known_op;
    logic [7:0]  w_arg;
    logic [7:0]  w_led_nxt;
    logic [15:0] w_good_inc;
    logic [15:0] w_bad_inc;

    assign w_accept   = s_udp_payload_axis_tvalid && r_s_tready;
    // A frame ending in B2 carries ARG on the tlast beat itself; later frames use the latched ARG.
    assign w_arg      = (r_state == B2) ? s_udp_payload_axis_tdata : r_arg;
    assign w_end_good = w_accept && s_udp_payload_axis_tlast && !s_udp_payload_axis_tuser &&
                        ((r_state == B2) || ((r_state == DRAIN) && !r_bad_magic));
    assign w_end_bad  = w_accept && s_udp_payload_axis_tlast && !w_end_good;
    assign w_good_inc = (r_good_cnt == 16'hFFFF) ? r_good_cnt : r_good_cnt + 16'd1;
    assign w_bad_inc  = (r_bad_cnt  == 16'hFFFF) ? r_bad_cnt  : r_bad_cnt  + 16'd1;

    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_led_nxt  = r_led;
        w_known_op = 1'b1;
        case (r_op)
            OP_WRITE: w_led_nxt = w_arg;
            OP_READ:  w_led_nxt = r_led;
            OP_XOR:   w_led_nxt = r_led ^ w_arg;
            default:  w_known_op = 1'b0;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= B0;
            r_s_tready  <= 1'b0;
            r_m_tdata   <= 8'h00;
            r_m_tvalid  <= 1'b0;
            r_m_tlast   <= 1'b0;
            r_led       <= LED_RESET;
            r_good_cnt  <= 16'h0000;
            r_bad_cnt   <= 16'h0000;
            r_op        <= 8'h00;
            r_arg       <= 8'h00;
            r_bad_magic <= 1'b0;
            r_rsp_b1    <= 8'h00;
            r_rsp_b2    <= 8'h00;
            r_rsp_idx   <= 2'd0;
        end else begin
            r_s_tready <= (r_state != RESP);
            if (w_end_good) begin
                r_led      <= w_led_nxt;
                r_good_cnt <= w_good_inc;
                r_rsp_b1   <= w_known_op ? (r_op | 8'h80) : 8'hFF;
                r_rsp_b2   <= w_led_nxt;
                r_rsp_idx  <= 2'd0;
                r_m_tdata  <= MAGIC;
                r_m_tvalid <= 1'b1;
                r_m_tlast  <= 1'b0;
                r_s_tready <= 1'b0;
                r_state    <= RESP;
            end else if (w_end_bad) begin
                r_bad_cnt <= w_bad_inc;
                r_state   <= B0;
            end else begin
                case (r_state)
                    B0: if (w_accept) begin
                        r_bad_magic <= (s_udp_payload_axis_tdata != MAGIC);
                        r_state     <= (s_udp_payload_axis_tdata == MAGIC) ? B1 : DRAIN;
                    end
                    B1: if (w_accept) begin
                        r_op    <= s_udp_payload_axis_tdata;
                        r_state <= B2;
                    end
                    B2: if (w_accept) begin
                        r_arg   <= s_udp_payload_axis_tdata;
                        r_state <= DRAIN;
                    end
                    DRAIN: r_state <= DRAIN;
                    RESP: if (m_udp_payload_axis_tready) begin
                        case (r_rsp_idx)
                            2'd0: begin
                                r_m_tdata <= r_rsp_b1;
                                r_rsp_idx <= 2'd1;
                            end
                            2'd1: begin
                                r_m_tdata <= r_rsp_b2;
                                r_m_tlast <= 1'b1;
                                r_rsp_idx <= 2'd2;
                            end
                            default: begin
                                r_m_tvalid <= 1'b0;
                                r_m_tlast  <= 1'b0;
                                r_rsp_idx  <= 2'd0;
                                r_s_tready <= 1'b1;
                                r_state    <= B0;
                            end
                        endcase
                    end
                    default: r_state <= B0;
                endcase
            end
        end
    end

    assign s_udp_payload_axis_tready = r_s_tready;
    assign m_udp_payload_axis_tdata  = r_m_tdata;
    assign m_udp_payload_axis_tvalid = r_m_tvalid;
    assign m_udp_payload_axis_tlast  = r_m_tlast;
    assign m_udp_payload_axis_tuser  = 1'b0;
    assign led                       = r_led;
    assign good_frame_cnt            = r_good_cnt;
    assign bad_frame_cnt             = r_bad_cnt;

endmodule

// File: tb/tb_udp_cmd_parser.sv
`timescale 1ns/1ps
// Testbench for udp_cmd_parser: table of frames plus hand-written corner sequences,
// reply beats checked against a queue of expected bytes.
module tb_udp_cmd_parser;

    localparam logic [7:0] MAGIC   = 8'hA5;
    localparam logic [7:0] LED_RST = 8'h00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic        s_tuser = 1'b0;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic        m_tuser;
    logic [7:0]  led;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    always #4 clk = ~clk;

    udp_cmd_parser #(.MAGIC(MAGIC), .LED_RESET(LED_RST)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .s_udp_payload_axis_tdata  (s_tdata),
        .s_udp_payload_axis_tvalid (s_tvalid),
        .s_udp_payload_axis_tready (s_tready),
        .s_udp_payload_axis_tlast  (s_tlast),
        .s_udp_payload_axis_tuser  (s_tuser),
        .m_udp_payload_axis_tdata  (m_tdata),
        .m_udp_payload_axis_tvalid (m_tvalid),
        .m_udp_payload_axis_tready (m_tready),
        .m_udp_payload_axis_tlast  (m_tlast),
        .m_udp_payload_axis_tuser  (m_tuser),
        .led                       (led),
        .good_frame_cnt            (good_cnt),
        .bad_frame_cnt             (bad_cnt)
    );

    typedef struct {
        logic [5:0][7:0] b;
        int              len;
        logic            user;
        logic [7:0]      exp_led;
        bit              reply;
        logic [7:0]      exp_b1;
        int              exp_good;
        int              exp_bad;
    } vec_t;

    vec_t       vecs[13];
    logic [8:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input logic [7:0] b3, input int len, input logic user,
                                input logic [7:0] exp_led, input bit reply, input logic [7:0] exp_b1,
                                input int exp_good, input int exp_bad);
        vec_t v;
        v.b        = '0;
        v.b[0]     = b0;
        v.b[1]     = b1;
        v.b[2]     = b2;
        v.b[3]     = b3;
        v.len      = len;
        v.user     = user;
        v.exp_led  = exp_led;
        v.reply    = reply;
        v.exp_b1   = exp_b1;
        v.exp_good = exp_good;
        v.exp_bad  = exp_bad;
        return v;
    endfunction

    task automatic push_reply(input logic [7:0] b1, input logic [7:0] b2);
        exp_q.push_back({1'b0, MAGIC});
        exp_q.push_back({1'b0, b1});
        exp_q.push_back({1'b1, b2});
    endtask

    // Called at posedge+1; returns at posedge+1 right after the byte was accepted.
    task automatic send_byte(input logic [7:0] d, input logic last, input logic user);
        int w;
        if ($urandom_range(0, 3) == 0) begin
            s_tvalid = 1'b0;
            s_tdata  = 8'($urandom);
            s_tlast  = 1'b1;
            s_tuser  = 1'b1;
            @(posedge clk); #1;
        end
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        s_tuser  = user;
        w = 0;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            w++;
            if (w > 200) begin
                check("s_tready_timeout", 32'(s_tready), 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic send_frame(input logic [5:0][7:0] b, input int len, input logic user);
        for (int i = 0; i < len; i++)
            send_byte(b[i], (i == len - 1), user && (i == len - 1));
    endtask

    task automatic wait_drain(input string name);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check({name, "_tvalid_low"}, 32'(m_tvalid), 32'd0);
    endtask

    // Reply monitor: samples on the falling edge, i.e. the handshake about to happen.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst && m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_reply_beat", {23'd0, m_tlast, m_tdata}, 32'h1FF);
                end else begin
                    e = exp_q.pop_front();
                    check("reply_beat", {23'd0, m_tlast, m_tdata}, {23'd0, e});
                    check("reply_tuser", 32'(m_tuser), 32'd0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0][7:0] fb;

        vecs[0]  = mk(8'hA5, 8'h01, 8'h3C, 8'h00, 3, 1'b0, 8'h3C, 1'b1, 8'h81, 1, 0);
        vecs[1]  = mk(8'hA5, 8'h03, 8'hFF, 8'h00, 5, 1'b0, 8'hC3, 1'b1, 8'h83, 2, 0);
        vecs[2]  = mk(8'h5A, 8'h01, 8'h11, 8'h00, 3, 1'b0, 8'hC3, 1'b0, 8'h00, 2, 1);
        vecs[3]  = mk(8'hA5, 8'h01, 8'h00, 8'h00, 2, 1'b0, 8'hC3, 1'b0, 8'h00, 2, 2);
        vecs[4]  = mk(8'hA5, 8'h01, 8'h22, 8'h00, 3, 1'b1, 8'hC3, 1'b0, 8'h00, 2, 3);
        vecs[5]  = mk(8'hA5, 8'h02, 8'h00, 8'h00, 3, 1'b0, 8'hC3, 1'b1, 8'h82, 3, 3);
        vecs[6]  = mk(8'hA5, 8'h00, 8'h00, 8'h00, 1, 1'b0, 8'hC3, 1'b0, 8'h00, 3, 4);
        vecs[7]  = mk(8'h5A, 8'h00, 8'h00, 8'h00, 1, 1'b0, 8'hC3, 1'b0, 8'h00, 3, 5);
        vecs[8]  = mk(8'hA5, 8'h07, 8'h55, 8'h00, 3, 1'b0, 8'hC3, 1'b1, 8'hFF, 4, 5);
        vecs[9]  = mk(8'hA5, 8'h03, 8'h0F, 8'h99, 4, 1'b1, 8'hC3, 1'b0, 8'h00, 4, 6);
        vecs[10] = mk(8'h5A, 8'h03, 8'h0F, 8'h99, 4, 1'b0, 8'hC3, 1'b0, 8'h00, 4, 7);
        vecs[11] = mk(8'hA5, 8'h03, 8'h0F, 8'h99, 4, 1'b0, 8'hCC, 1'b1, 8'h83, 5, 7);
        vecs[12] = mk(8'hA5, 8'h01, 8'hA5, 8'h5A, 4, 1'b0, 8'hA5, 1'b1, 8'h81, 6, 7);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_led", 32'(led), 32'(LED_RST));
        check("rst_good", 32'(good_cnt), 32'd0);
        check("rst_bad", 32'(bad_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("s_tready_after_rst", 32'(s_tready), 32'd1);

        // Table-driven frames
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].reply) push_reply(vecs[i].exp_b1, vecs[i].exp_led);
            send_frame(vecs[i].b, vecs[i].len, vecs[i].user);
            check($sformatf("vec%0d_led_1cyc", i), 32'(led), 32'(vecs[i].exp_led));
            wait_drain($sformatf("vec%0d", i));
            check($sformatf("vec%0d_good", i), 32'(good_cnt), 32'(vecs[i].exp_good));
            check($sformatf("vec%0d_bad", i), 32'(bad_cnt), 32'(vecs[i].exp_bad));
        end

        // Unknown OP under reply backpressure: first byte held, input stalled
        m_tready = 1'b0;
        push_reply(8'hFF, 8'hA5);
        fb = '0; fb[0] = 8'hA5; fb[1] = 8'h07; fb[2] = 8'h55;
        send_frame(fb, 3, 1'b0);
        check("bp_first_tvalid", 32'(m_tvalid), 32'd1);
        check("bp_first_tdata", 32'(m_tdata), 32'hA5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_stall_beat", {22'd0, s_tready, m_tvalid, m_tlast, m_tdata}, {22'd0, 3'b010, 8'hA5});
        end
        @(posedge clk); #1;
        m_tready = 1'b1;
        wait_drain("bp");
        check("bp_led", 32'(led), 32'hA5);
        check("bp_good", 32'(good_cnt), 32'd7);

        // Reset in the middle of a reply, after its second byte
        m_tready = 1'b0;
        exp_q.push_back({1'b0, MAGIC});
        exp_q.push_back({1'b0, 8'h81});
        fb = '0; fb[0] = 8'hA5; fb[1] = 8'h01; fb[2] = 8'h77;
        send_frame(fb, 3, 1'b0);
        check("mid_led", 32'(led), 32'h77);
        m_tready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_tready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
        check("mid_rst_led", 32'(led), 32'(LED_RST));
        check("mid_rst_good", 32'(good_cnt), 32'd0);
        check("mid_rst_bad", 32'(bad_cnt), 32'd0);
        check("mid_rst_beats_seen", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        m_tready = 1'b1;
        push_reply(8'h82, 8'h00);
        fb = '0; fb[0] = 8'hA5; fb[1] = 8'h02; fb[2] = 8'h00;
        send_frame(fb, 3, 1'b0);
        wait_drain("post_rst");
        check("post_rst_good", 32'(good_cnt), 32'd1);

        // Counter saturation
        force dut.r_good_cnt = 16'hFFFF;
        @(posedge clk); #1;
        release dut.r_good_cnt;
        check("sat_preload", 32'(good_cnt), 32'h0000FFFF);
        push_reply(8'h82, 8'h00);
        send_frame(fb, 3, 1'b0);
        wait_drain("sat");
        check("sat_good", 32'(good_cnt), 32'h0000FFFF);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
